// File: rtl/seg_pkg.sv
// Shared definitions for the 4-digit 7-segment display path.
//   AN_*       : active-low one-hot anode patterns, one per digit slot
//   BCD_BLANK  : digit code the segment decoder renders as all segments off
//   conv_state_e : states of the sequential binary-to-BCD conversion
//   dabble_adj : double-dabble nibble correction (+3 when the nibble is >= 5)
package seg_pkg;

    localparam logic [3:0] AN_UNITS  = 4'b1110;
    localparam logic [3:0] AN_TENS   = 4'b1101;
    localparam logic [3:0] AN_HUND   = 4'b1011;
    localparam logic [3:0] AN_THOU   = 4'b0111;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_e;

    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin8_to_bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to 3 BCD digits.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   start_i : begin a conversion of bin_i (honoured in IDLE and COMMIT only)
//   bin_i   : binary value to convert
//   bcd_o   : {hundreds, tens, units}, valid while valid_o is high
//   valid_o : high for the single COMMIT cycle after the 8th shift
// A start during COMMIT reloads immediately, so back-to-back conversions
// take exactly 9 edges each.
module bin8_to_bcd_seq
    import seg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  bin_i,
    output logic [11:0] bcd_o,
    output logic        valid_o
);

    conv_state_e state_q;
    logic [19:0] sr_q;
    logic [2:0]  cnt_q;
    logic [19:0] sr_adj;

    always_comb begin
        sr_adj = {dabble_adj(sr_q[19:16]), dabble_adj(sr_q[15:12]),
                  dabble_adj(sr_q[11:8]), sr_q[7:0]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sr_q    <= {12'h000, bin_i};
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= {sr_adj[18:0], 1'b0};
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (start_i) begin
                        sr_q    <= {12'h000, bin_i};
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bcd_o   = sr_q[19:8];
    assign valid_o = (state_q == COMMIT);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Display sequencing controller: converts a loaded 8-bit value to BCD,
// applies optional leading-zero blanking and scans the 4 digits.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   data   : binary value, sampled on an edge where load=1
//   load   : single-cycle conversion request
//   anodes : active-low one-hot digit select (1110 = units ... 0111 = thousands)
//   digit  : BCD value of the selected digit, 4'hF = blank
//   busy   : conversion running or a value queued
//   done   : one-cycle pulse after new digits are committed
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       load,
    output logic [3:0] anodes,
    output logic [3:0] digit,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] refresh_q;
    logic          tick;
    logic [3:0]    anodes_q;
    logic [3:0]    thou_q, hund_q, tens_q, units_q;
    logic [3:0]    hund_d, tens_d, units_d;
    logic          pending_q;
    logic [7:0]    pend_val_q;
    logic          busy_q, busy_d;
    logic          done_q;

    logic          conv_start;
    logic [7:0]    conv_bin;
    logic [11:0]   conv_bcd;
    logic          conv_valid;

    bin8_to_bcd_seq u_bcd (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (conv_start),
        .bin_i   (conv_bin),
        .bcd_o   (conv_bcd),
        .valid_o (conv_valid)
    );

    assign tick = (refresh_q == CW'(REFRESH_DIV - 1));

    // A load on the commit edge is the newest value, so it restarts the
    // engine directly instead of sitting in the pending buffer.
    always_comb begin
        conv_start = (load && !busy_q) || (conv_valid && (load || pending_q));
        conv_bin   = load ? data : pend_val_q;
        busy_d     = busy_q;
        if (conv_start) begin
            busy_d = 1'b1;
        end else if (conv_valid) begin
            busy_d = 1'b0;
        end
    end

    // Tens are only blanked when hundreds are blanked too.
    always_comb begin
        units_d = conv_bcd[3:0];
        tens_d  = conv_bcd[7:4];
        hund_d  = conv_bcd[11:8];
        if (BLANK_LZ && conv_bcd[11:8] == 4'd0) begin
            hund_d = BCD_BLANK;
            if (conv_bcd[7:4] == 4'd0) begin
                tens_d = BCD_BLANK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            anodes_q  <= AN_UNITS;
        end else begin
            refresh_q <= tick ? '0 : refresh_q + 1'b1;
            if (tick) begin
                anodes_q <= {anodes_q[2:0], anodes_q[3]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= 1'b0;
            pend_val_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            thou_q     <= '0;
            hund_q     <= '0;
            tens_q     <= '0;
            units_q    <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= conv_valid;
            if (conv_valid) begin
                pending_q <= 1'b0;
                thou_q    <= BLANK_LZ ? BCD_BLANK : 4'h0;
                hund_q    <= hund_d;
                tens_q    <= tens_d;
                units_q   <= units_d;
            end else if (load && busy_q) begin
                pending_q  <= 1'b1;
                pend_val_q <= data;
            end
        end
    end

    always_comb begin
        unique case (anodes_q)
            AN_UNITS: digit = units_q;
            AN_TENS:  digit = tens_q;
            AN_HUND:  digit = hund_q;
            AN_THOU:  digit = thou_q;
            default:  digit = BCD_BLANK;
        endcase
    end

    assign anodes = anodes_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
